// File: rtl/fifo_rd_pack.sv
// Pops DSIZE-bit words from a first-word-fall-through FIFO and packs PACK of them
// into one wide word. Output side is a two-entry head/skid buffer with keep mask.
module fifo_rd_pack #(
  parameter int DSIZE = 8,
  parameter int PACK  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  partial
);

  localparam int CW = $clog2(PACK);
  localparam int WW = DSIZE * PACK;
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);

  logic [CW-1:0]   cnt;
  logic [WW-1:0]   asm_q;
  logic [WW-1:0]   word;
  logic [PACK-1:0] keep;
  logic [1:0]      occ;
  logic [WW-1:0]   skid_data;
  logic [PACK-1:0] skid_keep;
  logic            drain, space, pop, push;

  assign drain = out_valid && out_ready;
  assign space = (occ != 2'd2) || drain;
  // gated by reset so a non-empty FIFO is never popped while held in reset
  assign pop   = rrst_n && !rempty && (((cnt != LAST) && !flush) || space);
  assign push  = (pop && (cnt == LAST)) || (flush && space && ((cnt != '0) || pop));
  assign rinc  = pop;

  assign out_valid = (occ != 2'd0);
  assign partial   = (cnt != '0);

  // word to push this cycle: assembled lanes plus any byte popped right now
  always_comb begin
    int fill;
    word = asm_q;
    if (pop) word[int'(cnt)*DSIZE +: DSIZE] = rdata;
    fill = int'(cnt) + (pop ? 1 : 0);
    keep = '0;
    for (int k = 0; k < PACK; k++) keep[k] = (k < fill);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (push) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (pop) begin
      cnt   <= cnt + CW'(1);
      asm_q <= word;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ       <= 2'd0;
      out_data  <= '0;
      out_keep  <= '0;
      skid_data <= '0;
      skid_keep <= '0;
    end else begin
      case ({push, drain})
        2'b10: begin
          if (occ == 2'd0) begin
            out_data <= word;
            out_keep <= keep;
          end else begin
            skid_data <= word;
            skid_keep <= keep;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          out_data  <= skid_data;
          out_keep  <= skid_keep;
          skid_data <= '0;
          skid_keep <= '0;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            out_data  <= skid_data;
            out_keep  <= skid_keep;
            skid_data <= word;
            skid_keep <= keep;
          end else begin
            out_data <= word;
            out_keep <= keep;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed bench for fifo_rd_pack with a small FWFT FIFO model feeding it.
module tb_fifo_rd_pack;

  logic        rclk;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        partial;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rd_ptr = 8'd0;
  logic [7:0] wr_ptr = 8'd0;
  logic       hold   = 1'b1;
  logic [7:0] start;

  assign rempty = hold || (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr];

  always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 8'd1;

  fifo_rd_pack #(.DSIZE(8), .PACK(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .partial(partial)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic load(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; hold = 1'b1;
    repeat (3) @(negedge rclk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (partial !== 1'b0) begin errors++; $display("FAIL reset_partial got %b exp 0", partial); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep got %h exp 0", out_keep); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b exp 0", rinc); end
    rrst_n = 1'b1;
    @(negedge rclk);
  endtask

  task automatic test_stream();
    for (int b = 1; b <= 8; b++) load(8'(b));
    out_ready = 1'b1; flush = 1'b0;
    hold = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge rclk);
      if (i == 4) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_keep !== 4'hF) begin
          errors++; $display("FAIL stream_w0 got v=%b d=%h k=%h exp 1 04030201 f", out_valid, out_data, out_keep); end
        checks++; if (partial !== 1'b0) begin errors++; $display("FAIL stream_wrap_partial got %b exp 0", partial); end
      end else if (i == 8) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h08070605 || out_keep !== 4'hF) begin
          errors++; $display("FAIL stream_w1 got v=%b d=%h k=%h exp 1 08070605 f", out_valid, out_data, out_keep); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_%0d got valid %b exp 0", i, out_valid); end
      end
      if (i == 2) begin
        checks++; if (partial !== 1'b1) begin errors++; $display("FAIL stream_partial got %b exp 1", partial); end
      end
    end
  endtask

  task automatic test_backpressure();
    hold = 1'b1;
    for (int b = 8'h21; b <= 8'h2C; b++) load(8'(b));
    out_ready = 1'b0;
    start = rd_ptr;
    hold = 1'b0;
    repeat (14) @(negedge rclk);
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL bp_stall_rinc got %b exp 0", rinc); end
    checks++; if (rd_ptr !== 8'(start + 8'd11)) begin errors++; $display("FAIL bp_pops got %0d exp 11", 8'(rd_ptr - start)); end
    checks++; if (partial !== 1'b1) begin errors++; $display("FAIL bp_partial got %b exp 1", partial); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h24232221) begin
      errors++; $display("FAIL bp_head got v=%b d=%h exp 1 24232221", out_valid, out_data); end
    flush = 1'b1;
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL bp_flush_rinc got %b exp 0", rinc); end
    @(negedge rclk);
    checks++; if (partial !== 1'b1 || rd_ptr !== 8'(start + 8'd11) || out_data !== 32'h24232221) begin
      errors++; $display("FAIL bp_flush_hold got p=%b pops=%0d d=%h exp 1 11 24232221", partial, 8'(rd_ptr - start), out_data); end
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL bp_resume_rinc got %b exp 1", rinc); end
    @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h28272625) begin
      errors++; $display("FAIL bp_word1 got v=%b d=%h exp 1 28272625", out_valid, out_data); end
    @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h2C2B2A29 || out_keep !== 4'hF) begin
      errors++; $display("FAIL bp_word2 got v=%b d=%h k=%h exp 1 2c2b2a29 f", out_valid, out_data, out_keep); end
    @(negedge rclk);
    checks++; if (out_valid !== 1'b0 || partial !== 1'b0) begin
      errors++; $display("FAIL bp_drained got v=%b p=%b exp 0 0", out_valid, partial); end
  endtask

  task automatic test_flush();
    hold = 1'b1;
    load(8'hAA); load(8'hBB);
    out_ready = 1'b1;
    hold = 1'b0;
    repeat (2) @(negedge rclk);
    checks++; if (partial !== 1'b1 || rinc !== 1'b0) begin
      errors++; $display("FAIL flush_pre got p=%b rinc=%b exp 1 0", partial, rinc); end
    flush = 1'b1;
    @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_keep !== 4'h3) begin
      errors++; $display("FAIL flush_word got v=%b d=%h k=%h exp 1 0000bbaa 3", out_valid, out_data, out_keep); end
    checks++; if (partial !== 1'b0) begin errors++; $display("FAIL flush_partial got %b exp 0", partial); end
    repeat (2) begin
      @(negedge rclk);
      checks++; if (out_valid !== 1'b0 || partial !== 1'b0) begin
        errors++; $display("FAIL flush_noop got v=%b p=%b exp 0 0", out_valid, partial); end
    end
    flush = 1'b0;
  endtask

  task automatic test_flush_pop();
    hold = 1'b1;
    load(8'hAA); load(8'hBB); load(8'hCC);
    out_ready = 1'b1;
    start = rd_ptr;
    hold = 1'b0;
    repeat (2) @(negedge rclk);
    flush = 1'b1;
    #1;
    checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL fpop_rinc got %b exp 1", rinc); end
    @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h00CCBBAA || out_keep !== 4'h7) begin
      errors++; $display("FAIL fpop_word got v=%b d=%h k=%h exp 1 00ccbbaa 7", out_valid, out_data, out_keep); end
    checks++; if (rd_ptr !== 8'(start + 8'd3)) begin errors++; $display("FAIL fpop_pops got %0d exp 3", 8'(rd_ptr - start)); end
    flush = 1'b0;
    @(negedge rclk);
  endtask

  task automatic test_reset_midword();
    out_ready = 1'b0;
    load(8'h77);
    @(negedge rclk);
    flush = 1'b1;
    @(negedge rclk);
    flush = 1'b0;
    load(8'h55); load(8'h66);
    repeat (2) @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || partial !== 1'b1) begin
      errors++; $display("FAIL rmid_pre got v=%b p=%b exp 1 1", out_valid, partial); end
    load(8'h11); load(8'h12); load(8'h13); load(8'h14);
    start = rd_ptr;
    rrst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || partial !== 1'b0 || out_keep !== 4'h0) begin
      errors++; $display("FAIL rmid_async got v=%b p=%b k=%h exp 0 0 0", out_valid, partial, out_keep); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL rmid_rinc got %b exp 0", rinc); end
    @(negedge rclk);
    checks++; if (rd_ptr !== start) begin errors++; $display("FAIL rmid_nopop got %0d pops exp 0", 8'(rd_ptr - start)); end
    out_ready = 1'b1;
    rrst_n = 1'b1;
    repeat (4) @(negedge rclk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h14131211 || out_keep !== 4'hF) begin
      errors++; $display("FAIL rmid_word got v=%b d=%h k=%h exp 1 14131211 f", out_valid, out_data, out_keep); end
    @(negedge rclk);
  endtask

  task automatic test_empty_guard();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      flush = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL empty_rinc_%0d got %b exp 0", i, rinc); end
      @(negedge rclk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid_%0d got %b exp 0", i, out_valid); end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_pop();
    test_reset_midword();
    test_empty_guard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
